row_bram_xfer: RTL and testbench
================================

Name: row_bram_xfer

Overview:
Parametrised wide-row ⇄ BRAM word mover for the connected-domain filter datapath.
- Write mode: splits one ROW_W-bit image row into N_WORDS BRAM words and writes them at consecutive addresses.
- Read mode: reads N_WORDS words back and reassembles the row.
- Words move back-to-back, one per acknowledged cycle, with no idle cycle between words. The block sits between the row-processing engines and the BRAM port arbiter.

Parameters:
ROW_W, 512, row width in bits
WORD_W, 32, BRAM word width; ROW_W % WORD_W == 0 required
ROW_AW, 9, row-number width (max 2^ROW_AW rows)
MSB_FIRST, 1, 1: word 0 = row[ROW_W-1 -: WORD_W]; 0: word 0 = row[WORD_W-1:0]
Derived constants:
- N_WORDS = ROW_W/WORD_W, which must be a power of 2.
- WORD_AW = clog2(N_WORDS).
- Elaboration error if either of these constraints is violated.

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_trig  in  1  start request, level; must stay high until o_done
i_mode  in  1  0 = write row, 1 = read row; sampled at start
i_row_num  in  ROW_AW  target row; sampled at start
i_row_data  in  ROW_W  row to write; sampled at start
o_rd_row  out  ROW_W  reassembled row (read mode); valid while o_done=1
o_busy  out  1  transfer in progress
o_done  out  1  transfer complete, held until i_trig low
o_bram_req  out  1  word request to BRAM arbiter
o_bram_we  out  1  1 = write, 0 = read; valid with o_bram_req
o_bram_addr  out  ROW_AW+WORD_AW  {row_num, word_idx}
o_bram_wdata  out  WORD_W  write word
i_bram_rdata  in  WORD_W  read word, valid with i_bram_ack when o_bram_we=0
i_bram_ack  in  1  word accepted/completed this cycle

Behaviour:
- All outputs are registered.
- Reset values: o_busy, o_done, o_bram_req and o_bram_we are 0; o_bram_addr, o_bram_wdata and o_rd_row are 0; state is IDLE; word_idx is 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - If i_trig=1 at edge t: capture i_mode, i_row_num and i_row_data into internal regs, set word_idx=0, go to XFER.
  - After edge t: o_busy=1, o_bram_req=1, o_bram_we=~mode, o_bram_addr={row,0}, o_bram_wdata=word(0).
- XFER:
  - o_bram_req stays 1.
  - On i_bram_ack=1:
    - Read mode: store i_bram_rdata into row slot word_idx, using the same MSB_FIRST mapping as writes.
    - If word_idx == N_WORDS-1: go to DONE, drop o_bram_req and o_busy, set o_done=1.
    - Otherwise: word_idx+1, and update addr/wdata to the next word in the same edge, giving zero bubbles.
  - With ack held high, word k is acked at edge t+1+k and o_done rises after edge t+N_WORDS.
  - No ack: addr, wdata and req hold stable (standard req/ack hold rule).
- DONE:
  - o_done=1; o_rd_row holds the assembled row.
  - When i_trig=0: go to IDLE, o_done=0. o_done is therefore high for at least one cycle.
  - A new transfer needs i_trig low then high, which gives a clean level handshake.
- Boundary conditions:
  - i_bram_ack while o_bram_req=0 (IDLE/DONE): ignored.
  - i_trig dropped mid-XFER: ignored; the transfer completes, o_done pulses one cycle, then IDLE.
  - i_row_data, i_row_num or i_mode changing mid-transfer: no effect, because values are captured at start.
  - Last row (row_num = 2^ROW_AW-1) and last word: addr = all ones, no wrap into another row.
  - Write mode: o_rd_row is unchanged from the previous read.
  - Async reset mid-XFER: immediately returns all outputs to reset values, including req; a partial row may remain in BRAM.

Decomposition:
- Package cdf_bram_pkg:
  - mode constants MODE_WR=0, MODE_RD=1
  - state enum {IDLE, XFER, DONE}
  - function clog2, and a function word_slice(row, idx, msb_first) used by both write select and read insert
- One natural sub-module: row_word_mux. It holds the combinational word select plus registered word insert of the ROW_W shift/slot register. The FSM stays in row_bram_xfer.

Test Plan:
1. Defaults, write, ack held high, row 5, row = 512'h0001_0002_…_0010 (word k = k+1, MSB_FIRST) -> 16 consecutive acked cycles; addr 0x050..0x05F; wdata 1..16; o_done after edge t+16.
2. Read, row 511, BRAM model returns addr as data, ack every other cycle -> addrs 0x1FF0..0x1FFF; req held during gaps; o_rd_row word k = 0x1FF0+k; o_done after 32 cycles.
3. MSB_FIRST=0, ROW_W=128, WORD_W=32, write 128'hDDDD_CCCC_BBBB_AAAA -> wdata order AAAA, BBBB, CCCC, DDDD.
4. i_trig dropped after 3 words; i_row_data changed at word 2 -> all 16 original words written; o_done one-cycle pulse; then IDLE.
5. Async reset asserted at word 7 -> req/busy/done go 0 without a clock; after release with i_trig=1, restart from word 0.
6. Spurious ack in IDLE and DONE; trig held high in DONE -> no address/state change; o_done stays 1 until trig low.

Source files
------------

// File: rtl/cdf_bram_pkg.sv
// Shared definitions for the connected-domain filter BRAM movers.
//   MODE_WR / MODE_RD : transfer direction as seen on i_mode
//   xfer_state_t      : row mover FSM states
//   clog2             : elaboration-time ceil(log2)
//   word_slice        : bit offset of word idx inside a row; the write select
//                       and the read insert both use it, so a row always comes
//                       back from BRAM in the same word order it went in
package cdf_bram_pkg;

    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } xfer_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // msb_first=1 puts word 0 in the top WORD_W bits of the row
    function automatic int word_slice(input int n_words, input int word_w,
                                      input int idx, input bit msb_first);
        return (msb_first ? (n_words - 1 - idx) : idx) * word_w;
    endfunction

endpackage

// File: rtl/row_word_mux.sv
// Row <-> word datapath for row_bram_xfer.
//   i_load / i_row_data          : capture the row to be written
//   i_sel_idx -> o_sel_word      : combinational word select; while i_load is
//                                  high the incoming row is used directly so
//                                  word 0 can be registered on the start edge
//   i_ins / i_ins_idx / i_ins_word : registered insert into the read row
//   o_rd_row                     : assembled read row (only read inserts touch it)
module row_word_mux
    import cdf_bram_pkg::*;
#(
    parameter int ROW_W     = 512,
    parameter int WORD_W    = 32,
    parameter int WORD_AW   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_load,
    input  logic [ROW_W-1:0]   i_row_data,
    input  logic [WORD_AW-1:0] i_sel_idx,
    output logic [WORD_W-1:0]  o_sel_word,
    input  logic               i_ins,
    input  logic [WORD_AW-1:0] i_ins_idx,
    input  logic [WORD_W-1:0]  i_ins_word,
    output logic [ROW_W-1:0]   o_rd_row
);

    localparam int N_WORDS = ROW_W / WORD_W;

    logic [ROW_W-1:0] wr_row_q;
    logic [ROW_W-1:0] sel_src;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_row_q <= '0;
        end else if (i_load) begin
            wr_row_q <= i_row_data;
        end
    end

    assign sel_src = i_load ? i_row_data : wr_row_q;

    always_comb begin
        o_sel_word = sel_src[word_slice(N_WORDS, WORD_W, int'(i_sel_idx), MSB_FIRST != 0) +: WORD_W];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rd_row <= '0;
        end else if (i_ins) begin
            o_rd_row[word_slice(N_WORDS, WORD_W, int'(i_ins_idx), MSB_FIRST != 0) +: WORD_W] <= i_ins_word;
        end
    end

endmodule

// File: rtl/row_bram_xfer.sv
// Wide-row <-> BRAM word mover. Write mode splits a ROW_W row into N_WORDS
// words written at {row, word_idx}; read mode reads them back and rebuilds the
// row. Words issue back-to-back: the next address/word is loaded on the same
// edge that acks the current one.
//   i_trig/i_mode/i_row_num/i_row_data : level start request and its operands,
//                                        captured when leaving IDLE
//   o_busy/o_done/o_rd_row             : status and assembled read row
//   o_bram_req/we/addr/wdata           : word request to the BRAM arbiter,
//                                        held stable until i_bram_ack
//   i_bram_rdata/i_bram_ack            : completion and read data
module row_bram_xfer
    import cdf_bram_pkg::*;
#(
    parameter int ROW_W     = 512,
    parameter int WORD_W    = 32,
    parameter int ROW_AW    = 9,
    parameter int MSB_FIRST = 1
) (
    input  logic                                         i_clk,
    input  logic                                         i_rstn,
    input  logic                                         i_trig,
    input  logic                                         i_mode,
    input  logic [ROW_AW-1:0]                            i_row_num,
    input  logic [ROW_W-1:0]                             i_row_data,
    output logic [ROW_W-1:0]                             o_rd_row,
    output logic                                         o_busy,
    output logic                                         o_done,
    output logic                                         o_bram_req,
    output logic                                         o_bram_we,
    output logic [ROW_AW+clog2(ROW_W/WORD_W)-1:0]        o_bram_addr,
    output logic [WORD_W-1:0]                            o_bram_wdata,
    input  logic [WORD_W-1:0]                            i_bram_rdata,
    input  logic                                         i_bram_ack
);

    localparam int N_WORDS = ROW_W / WORD_W;
    localparam int WORD_AW = clog2(N_WORDS);
    localparam int ADDR_W  = ROW_AW + WORD_AW;
    localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(N_WORDS - 1);

    // Single-word rows would need a zero-width word index, so N_WORDS >= 2.
    if (ROW_W % WORD_W != 0) begin : g_bad_div
        $error("row_bram_xfer: ROW_W must be a multiple of WORD_W");
    end
    if (N_WORDS < 2 || (N_WORDS & (N_WORDS - 1)) != 0) begin : g_bad_pow2
        $error("row_bram_xfer: ROW_W/WORD_W must be a power of 2 (>= 2)");
    end

    xfer_state_t        state_q, state_d;
    logic [WORD_AW-1:0] idx_q, idx_d;
    logic               mode_q, mode_d;
    logic               busy_d, done_d, req_d, we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [WORD_W-1:0]  wdata_d;

    logic               load;
    logic               ins;
    logic [WORD_AW-1:0] sel_idx;
    logic [WORD_W-1:0]  sel_word;

    assign load    = (state_q == IDLE) && i_trig;
    assign ins     = (state_q == XFER) && i_bram_ack && (mode_q == MODE_RD);
    // Look one word ahead so wdata is ready on the acking edge; the wrap at
    // the last word is harmless because that edge leaves XFER.
    assign sel_idx = (state_q == IDLE) ? '0 : idx_q + WORD_AW'(1);

    row_word_mux #(
        .ROW_W     (ROW_W),
        .WORD_W    (WORD_W),
        .WORD_AW   (WORD_AW),
        .MSB_FIRST (MSB_FIRST)
    ) u_mux (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (load),
        .i_row_data (i_row_data),
        .i_sel_idx  (sel_idx),
        .o_sel_word (sel_word),
        .i_ins      (ins),
        .i_ins_idx  (idx_q),
        .i_ins_word (i_bram_rdata),
        .o_rd_row   (o_rd_row)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        busy_d  = o_busy;
        done_d  = o_done;
        req_d   = o_bram_req;
        we_d    = o_bram_we;
        addr_d  = o_bram_addr;
        wdata_d = o_bram_wdata;
        case (state_q)
            IDLE: begin
                if (i_trig) begin
                    state_d = XFER;
                    idx_d   = '0;
                    mode_d  = i_mode;
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    we_d    = (i_mode == MODE_WR);
                    addr_d  = {i_row_num, {WORD_AW{1'b0}}};
                    wdata_d = sel_word;
                end
            end
            XFER: begin
                if (i_bram_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + WORD_AW'(1);
                        // low WORD_AW bits never overflow here, so +1 stays in the row
                        addr_d  = o_bram_addr + ADDR_W'(1);
                        wdata_d = sel_word;
                    end
                end
            end
            DONE: begin
                if (!i_trig) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            mode_q       <= MODE_WR;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_bram_req   <= 1'b0;
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
            o_bram_req   <= req_d;
            o_bram_we    <= we_d;
            o_bram_addr  <= addr_d;
            o_bram_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_row_bram_xfer.sv
// Bench for row_bram_xfer: a BRAM model (word array) answers requests with
// held, alternating or random acks; every acked beat is logged and compared
// against the word sequence a row must produce, and read rows are compared
// against rows assembled from the BRAM model. A second instance covers
// MSB_FIRST=0 with 128-bit rows.
module tb_row_bram_xfer;

    localparam int NW = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic         trig, mode;
    logic [8:0]   row_num;
    logic [511:0] row_data, rd_row;
    logic         busy, done, req, we, ack;
    logic [12:0]  addr;
    logic [31:0]  wdata, rdata;

    logic         b_trig, b_mode, b_busy, b_done, b_req, b_we, b_ack;
    logic [8:0]   b_row;
    logic [127:0] b_data, b_rd_row;
    logic [10:0]  b_addr;
    logic [31:0]  b_wdata, b_rdata;

    always #5 clk = ~clk;

    row_bram_xfer #(.ROW_W(512), .WORD_W(32), .ROW_AW(9), .MSB_FIRST(1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_trig(trig), .i_mode(mode),
        .i_row_num(row_num), .i_row_data(row_data), .o_rd_row(rd_row),
        .o_busy(busy), .o_done(done), .o_bram_req(req), .o_bram_we(we),
        .o_bram_addr(addr), .o_bram_wdata(wdata), .i_bram_rdata(rdata),
        .i_bram_ack(ack)
    );

    row_bram_xfer #(.ROW_W(128), .WORD_W(32), .ROW_AW(9), .MSB_FIRST(0)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_trig(b_trig), .i_mode(b_mode),
        .i_row_num(b_row), .i_row_data(b_data), .o_rd_row(b_rd_row),
        .o_busy(b_busy), .o_done(b_done), .o_bram_req(b_req), .o_bram_we(b_we),
        .o_bram_addr(b_addr), .o_bram_wdata(b_wdata), .i_bram_rdata(b_rdata),
        .i_bram_ack(b_ack)
    );

    assign b_rdata = 32'hA500_0000 | {21'b0, b_addr};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // BRAM model and beat log
    logic [31:0]  mem [0:8191];
    logic [12:0]  log_addr [$];
    logic [31:0]  log_data [$];
    logic [10:0]  b_alog [$];
    logic [31:0]  b_wlog [$];
    logic [511:0] last_rd;
    int           ack_mode;   // 0 held high, 1 every other cycle, 2 random
    bit           spur;       // ack driven while no request is pending
    bit           tog;

    always @(negedge clk) begin
        if (!req) tog = 1'b0;
        if (req) begin
            case (ack_mode)
                0:       ack = 1'b1;
                1:       begin ack = tog; tog = ~tog; end
                default: ack = 1'($urandom_range(0, 1));
            endcase
        end else begin
            ack = spur;
        end
        rdata = mem[addr];
    end

    always @(posedge clk) begin
        if (rstn && req && ack) begin
            log_addr.push_back(addr);
            log_data.push_back(we ? wdata : rdata);
        end
        if (rstn && b_req && b_ack) begin
            b_alog.push_back(b_addr);
            b_wlog.push_back(b_wdata);
        end
    end

    // word k of a row, word 0 in the top 32 bits
    function automatic logic [31:0] exp_word(input logic [511:0] r, input int k);
        logic [511:0] s;
        s = r >> (32 * (NW - 1 - k));
        return s[31:0];
    endfunction

    function automatic logic [511:0] rand_row();
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < NW; k++) r = {r[479:0], 32'($urandom)};
        return r;
    endfunction

    task automatic wait_log(input int n);
        int g;
        g = 0;
        while (log_addr.size() < n && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (log_addr.size() < n) chk("wait_log_timeout", 512'(log_addr.size()), 512'(n));
    endtask

    // Called one negedge after the start edge; watches req/hold until o_done.
    task automatic wait_done(output int cyc);
        int prev_n, herr, rerr;
        logic [12:0] prev_a;
        logic [31:0] prev_w;
        herr = 0; rerr = 0; cyc = 0;
        prev_n = log_addr.size(); prev_a = addr; prev_w = wdata;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!done) begin
                if (!req || !busy) rerr++;
                if (log_addr.size() == prev_n && (addr !== prev_a || wdata !== prev_w)) herr++;
            end
            prev_n = log_addr.size(); prev_a = addr; prev_w = wdata;
        end
        chk("done_seen", 512'(done), 512'(1));
        chk("req_held", 512'(rerr), 512'(0));
        chk("hold_stable", 512'(herr), 512'(0));
    endtask

    task automatic run_xfer(input bit m, input logic [8:0] rn, input logic [511:0] rd,
                            input int am, output int cyc);
        log_addr.delete(); log_data.delete();
        ack_mode = am;
        @(negedge clk);
        mode = m; row_num = rn; row_data = rd; trig = 1'b1;
        @(negedge clk);
        chk("start_req", 512'(req), 512'(1));
        chk("start_busy", 512'(busy), 512'(1));
        chk("start_addr", 512'(addr), 512'({rn, 4'h0}));
        chk("start_we", 512'(we), 512'(!m));
        if (!m) chk("start_wdata", 512'(wdata), 512'(exp_word(rd, 0)));
        wait_done(cyc);
        chk("done_busy", 512'(busy), 512'(0));
        chk("done_req", 512'(req), 512'(0));
    endtask

    task automatic end_xfer();
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        chk("done_clear", 512'(done), 512'(0));
    endtask

    task automatic verify(input bit m, input logic [8:0] rn, input logic [511:0] rd);
        int ae, de, a;
        logic [511:0] er;
        logic [31:0] w;
        ae = 0; de = 0; er = '0;
        chk("n_words", 512'(log_addr.size()), 512'(NW));
        for (int k = 0; k < log_addr.size() && k < NW; k++) begin
            a = int'(rn) * NW + k;
            if (int'(log_addr[k]) != a) ae++;
            w = m ? mem[a] : exp_word(rd, k);
            if (log_data[k] !== w) de++;
        end
        chk("seq_addr", 512'(ae), 512'(0));
        chk("seq_data", 512'(de), 512'(0));
        if (!m) begin
            for (int k = 0; k < NW; k++) mem[int'(rn) * NW + k] = exp_word(rd, k);
            chk("wr_keeps_rd_row", rd_row, last_rd);
        end else begin
            for (int k = 0; k < NW; k++)
                er = er | (512'(mem[int'(rn) * NW + k]) << (32 * (NW - 1 - k)));
            chk("rd_row", rd_row, er);
            last_rd = er;
        end
    endtask

    initial begin
        int cyc, derr, n0;
        logic [511:0] r, d;
        logic [12:0] pa;
        logic [127:0] be;
        bit m;
        logic [8:0] rn;

        rstn = 1'b0; trig = 1'b0; mode = 1'b0; row_num = '0; row_data = '0;
        b_trig = 1'b0; b_mode = 1'b0; b_row = '0; b_data = '0; b_ack = 1'b1;
        ack = 1'b0; ack_mode = 0; spur = 1'b0; tog = 1'b0; last_rd = '0;
        for (int a = 0; a < 8192; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_req", 512'(req), 512'(0));
        chk("rst_we", 512'(we), 512'(0));
        chk("rst_addr", 512'(addr), 512'(0));
        chk("rst_wdata", 512'(wdata), 512'(0));
        chk("rst_rd_row", rd_row, 512'(0));
        rstn = 1'b1;

        // write row 5, word k = k+1, ack held
        r = '0;
        for (int k = 0; k < NW; k++) r[(NW - 1 - k) * 32 +: 32] = 32'(k + 1);
        run_xfer(1'b0, 9'd5, r, 0, cyc);
        chk("t1_latency", 512'(cyc), 512'(16));
        verify(1'b0, 9'd5, r);
        end_xfer();

        // read last row, data = address, ack every other cycle
        for (int k = 0; k < NW; k++) mem[13'h1FF0 + k] = 32'h1FF0 + 32'(k);
        run_xfer(1'b1, 9'd511, '0, 1, cyc);
        chk("t2_latency", 512'(cyc), 512'(32));
        verify(1'b1, 9'd511, '0);
        chk("t2_last_addr", 512'((log_addr.size() > 0) ? log_addr[$] : 13'h0), 512'(13'h1FFF));
        end_xfer();

        // trig dropped after 3 words, operands changed at word 2
        d = rand_row();
        log_addr.delete(); log_data.delete();
        ack_mode = 0;
        @(negedge clk);
        mode = 1'b0; row_num = 9'd3; row_data = d; trig = 1'b1;
        @(negedge clk);
        wait_log(2);
        row_data = ~d; row_num = 9'd7; mode = 1'b1;
        wait_log(3);
        trig = 1'b0;
        wait_done(cyc);
        @(negedge clk);
        chk("t4_done_pulse", 512'(done), 512'(0));
        chk("t4_idle_req", 512'(req), 512'(0));
        verify(1'b0, 9'd3, d);
        @(negedge clk);
        chk("t4_stay_idle", 512'(busy), 512'(0));

        // async reset at word 7, restart with trig still high
        d = rand_row();
        log_addr.delete(); log_data.delete();
        @(negedge clk);
        mode = 1'b0; row_num = 9'd9; row_data = d; trig = 1'b1;
        @(negedge clk);
        wait_log(7);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_req", 512'(req), 512'(0));
        chk("t5_rst_busy", 512'(busy), 512'(0));
        chk("t5_rst_done", 512'(done), 512'(0));
        chk("t5_rst_addr", 512'(addr), 512'(0));
        @(negedge clk);
        rstn = 1'b1;
        log_addr.delete(); log_data.delete();
        last_rd = '0;
        @(negedge clk);
        chk("t5_restart_req", 512'(req), 512'(1));
        chk("t5_restart_addr", 512'(addr), 512'({9'd9, 4'h0}));
        chk("t5_restart_wdata", 512'(wdata), 512'(exp_word(d, 0)));
        wait_done(cyc);
        chk("t5_latency", 512'(cyc), 512'(16));
        verify(1'b0, 9'd9, d);
        end_xfer();

        // spurious acks in IDLE and DONE, trig held in DONE
        pa = addr;
        spur = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_idle_req", 512'(req), 512'(0));
        chk("t6_idle_busy", 512'(busy), 512'(0));
        chk("t6_idle_addr", 512'(addr), 512'(pa));
        spur = 1'b0;
        d = rand_row();
        run_xfer(1'b0, 9'd100, d, 0, cyc);
        verify(1'b0, 9'd100, d);
        pa = addr; n0 = log_addr.size(); derr = 0;
        spur = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!done) derr++;
        end
        chk("t6_done_held", 512'(derr), 512'(0));
        chk("t6_done_addr", 512'(addr), 512'(pa));
        chk("t6_done_nobeat", 512'(log_addr.size()), 512'(n0));
        spur = 1'b0;
        end_xfer();

        // random transfers
        for (int i = 0; i < 20; i++) begin
            m = 1'($urandom_range(0, 1));
            rn = 9'($urandom);
            d = rand_row();
            if (m) for (int k = 0; k < NW; k++) mem[int'(rn) * NW + k] = $urandom;
            run_xfer(m, rn, d, int'($urandom_range(0, 2)), cyc);
            verify(m, rn, d);
            end_xfer();
        end

        // LSB-first instance: write then read
        b_alog.delete(); b_wlog.delete();
        @(negedge clk);
        b_mode = 1'b0; b_row = 9'd2;
        b_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        b_trig = 1'b1;
        cyc = 0;
        while (!b_done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("b_wr_done", 512'(b_done), 512'(1));
        chk("b_wr_beats", 512'(b_wlog.size()), 512'(4));
        for (int k = 0; k < b_wlog.size() && k < 4; k++) begin
            chk("b_wdata", 512'(b_wlog[k]), 512'({4{4'hA + 4'(k)}} << 16 | {4{4'hA + 4'(k)}}));
            chk("b_addr", 512'(b_alog[k]), 512'(8 + k));
        end
        b_trig = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_done_clear", 512'(b_done), 512'(0));
        @(negedge clk);
        b_mode = 1'b1; b_row = 9'd6; b_trig = 1'b1;
        cyc = 0;
        while (!b_done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("b_rd_done", 512'(b_done), 512'(1));
        be = {32'hA500_001B, 32'hA500_001A, 32'hA500_0019, 32'hA500_0018};
        chk("b_rd_row", 512'(b_rd_row), 512'(be));
        b_trig = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
